cu_sequencer: RTL and testbench
===============================

# cu_sequencer

Parametrised control-unit sequencer for the ThetaCore pipeline, sitting between the IDU and the ALU. It accepts one decoded instruction at a time through a valid/ready handshake and owns the general-purpose register file and PC. It issues the ALU command one cycle ahead of the operands, writes back results, and resolves branches and jumps. On any error, ECALL or EBREAK it enters a sticky halt with a reported cause; it never calls `$finish`.

## Interface

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, register count; power of two; x0 hardwired to zero.
- RESET_PC, 0, PC value at reset.
- TIMEOUT, 15, maximum cycles to wait for `alu_result_valid` (1..255).

Ports (RW = log2(NREG)):
- soc_clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; resets all state.
- IDU_ready  in  1  decoded instruction valid.
- cu_ready  out  1  sequencer can accept an instruction.
- Instruction_to_CU  in  6  instruction class; codes in package.
- Instruction_to_ALU  in  5  ALU opcode, passed through.
- imm  in  XLEN  immediate.
- rd, rs1, rs2  in  RW each  register indices.
- shamt  in  5  shift amount.
- pc_increment  in  XLEN  sequential PC step, normally 4.
- pipeline_override  in  2  bit0 selects the forward source for rs1; bit1 selects it for rs2.
- invalid_instruction  in  1  IDU decode error.
- alu_cmd  out  5  registered ALU opcode.
- alu_cmd_valid  out  1  one-cycle pulse.
- alu_in1, alu_in2  out  XLEN  operands.
- alu_dat_ready  out  1  one-cycle pulse; operands valid.
- alu_result  in  XLEN  result.
- alu_result_valid  in  1  result strobe.
- alu_branch_taken  in  1  compare outcome, sampled with `alu_result_valid`.
- ALU_err  in  1  ALU error.
- pc  out  XLEN  current PC.
- halted  out  1  sticky halt.
- halt_cause  out  3  0 none, 1 invalid, 2 alu_err, 3 ecall, 4 ebreak, 5 timeout.

## Operation

Instruction classes:
- CLS_ALU_R: in1=R[rs1], in2=R[rs2].
- CLS_ALU_I: in1=R[rs1], in2=imm.
- CLS_ALU_SH: in1=R[rs1], in2=zero-extended shamt.
- CLS_BRANCH: in1=R[rs1], in2=R[rs2]; no writeback.
- CLS_LUI: rd←imm; ALU bypassed.
- CLS_JAL: rd←pc+pc_increment; pc←pc+imm.
- CLS_JALR: rd←pc+pc_increment; pc←(R[rs1]+imm)&~1.
- CLS_ECALL, CLS_EBREAK: halt.
- Any other code is treated as invalid.

Forwarding:
- When an override bit is set, the corresponding operand comes from `last_wb` instead of the register file.
- `last_wb` holds the previous result even when that result's rd was x0. Code 2'b11 overrides both operands.

Register file and PC arithmetic:
- Writes to x0 are discarded; reads of x0 return 0.
- PC arithmetic is modulo 2^XLEN.

FSM states: IDLE, ISSUE, EXEC, WAIT, WB, JUMP, HALT.
- IDLE: `cu_ready`=1. Accept on IDU_ready&&cu_ready and latch all inputs.
  - `invalid_instruction` or ECALL/EBREAK → HALT.
  - LUI/JAL/JALR → JUMP.
  - Otherwise → ISSUE.
- ISSUE: drive `alu_cmd`, pulse `alu_cmd_valid` → EXEC.
- EXEC: drive operands, pulse `alu_dat_ready` → WAIT.
- WAIT: on `alu_result_valid` → WB. If the counter reaches TIMEOUT first → HALT, cause 5.
- WB: write rd (except for branches); pc←taken ? pc+imm : pc+pc_increment → IDLE.
- JUMP: perform the writeback and PC update → IDLE. JAL/JALR stall the pipeline for this whole sequence.
- HALT: terminal; `cu_ready`=0; only reset exits.

Error precedence:
- `ALU_err` in ISSUE, EXEC or WAIT → HALT with cause 2. No writeback and no PC update.
- `ALU_err` outranks a simultaneous `alu_result_valid`.
- `alu_result_valid` outside WAIT is ignored.

## Timing

- Reset values: pc=RESET_PC, all registers 0, last_wb=0, state IDLE, cu_ready=0, alu_cmd=0, alu_cmd_valid=0, alu_in1/2=0, alu_dat_ready=0, halted=0, halt_cause=0.
- `cu_ready` rises on the first rising edge after reset deasserts.
- Reset asserted mid-operation aborts immediately. No partial writeback survives.
- ALU path, with acceptance at edge 0:
  - `alu_cmd_valid` high in cycle 1.
  - `alu_dat_ready` high in cycle 2.
  - Result at the earliest in cycle 3; WB one cycle later.
  - `cu_ready` returns the cycle after WB.
  - Minimum issue interval is 5 cycles.
- LUI/JAL/JALR: `cu_ready` returns 2 cycles after acceptance.
- Invalid, ECALL, EBREAK: `halted` asserts the cycle after acceptance.
- `cu_ready` is low in every state except IDLE, including the acceptance cycle's successor.

## Structure

- `cu_pkg` holds:
  - class codes (CLS_*);
  - the state enum;
  - halt-cause constants;
  - the forwarding-select encoding.
- One sub-module, `cu_regfile`: NREG×XLEN, two combinational read ports, one synchronous write port, x0 masking, async active-low clear.

## Test plan

- **Reset then ALU-I.** Release reset, ADDI rd=5 rs1=0 imm=7, result 7 → R5=7, pc=4, `alu_cmd_valid` at cycle 1, `alu_dat_ready` at cycle 2.
- **Forwarding.**
  - Step 1: ADD rd=0, ALU returns 0x55; R0 stays 0.
  - Step 2: ADD rs1=0 with override=01 → `alu_in1`=0x55.
  - Step 3: same instruction with override=00 → `alu_in1`=0.
- **Branch.**
  - Taken, pc=0x10, imm=-8 → pc=0x08.
  - Not taken → pc=0x14; no register write.
- **JALR.** R3=0x101, imm=4, pc=0x20 → rd=0x24, pc=0x104 (LSB cleared), `cu_ready` back after 2 cycles.
- **Halt causes.**
  - `invalid_instruction` with IDU_ready → halted, cause 1, no `alu_cmd_valid`.
  - `ALU_err` together with `alu_result_valid` in WAIT → cause 2, rd unchanged.
  - EBREAK → cause 4.
- **Timeout and reset mid-op.**
  - No `alu_result_valid` for TIMEOUT cycles → halt, cause 5.
  - Reset asserted in WAIT → pc=RESET_PC, halted=0, registers cleared.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared encodings for the ThetaCore control-unit sequencer: instruction classes,
// FSM states, halt causes and forwarding-select bits.
package cu_pkg;

    localparam logic [5:0] CLS_ALU_R  = 6'h01;
    localparam logic [5:0] CLS_ALU_I  = 6'h02;
    localparam logic [5:0] CLS_ALU_SH = 6'h03;
    localparam logic [5:0] CLS_BRANCH = 6'h04;
    localparam logic [5:0] CLS_LUI    = 6'h05;
    localparam logic [5:0] CLS_JAL    = 6'h06;
    localparam logic [5:0] CLS_JALR   = 6'h07;
    localparam logic [5:0] CLS_ECALL  = 6'h08;
    localparam logic [5:0] CLS_EBREAK = 6'h09;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_EXEC,
        S_WAIT,
        S_WB,
        S_JUMP,
        S_HALT
    } state_e;

    localparam logic [2:0] HC_NONE    = 3'd0;
    localparam logic [2:0] HC_INVALID = 3'd1;
    localparam logic [2:0] HC_ALU_ERR = 3'd2;
    localparam logic [2:0] HC_ECALL   = 3'd3;
    localparam logic [2:0] HC_EBREAK  = 3'd4;
    localparam logic [2:0] HC_TIMEOUT = 3'd5;

    // Bit positions within pipeline_override.
    localparam int FWD_RS1 = 0;
    localparam int FWD_RS2 = 1;

    function automatic logic is_alu_cls(input logic [5:0] c);
        return (c == CLS_ALU_R) || (c == CLS_ALU_I) || (c == CLS_ALU_SH) || (c == CLS_BRANCH);
    endfunction

endpackage

// File: rtl/cu_regfile.sv
// General-purpose register file: two combinational reads, one synchronous write,
// x0 reads as zero and ignores writes.
module cu_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [$clog2(NREG)-1:0] raddr1,
    input  logic [$clog2(NREG)-1:0] raddr2,
    output logic [XLEN-1:0]         rdata1,
    output logic [XLEN-1:0]         rdata2,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] waddr,
    input  logic [XLEN-1:0]         wdata
);

    logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;

    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != '0)) regs_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) regs_q <= '0;
        else        regs_q <= regs_d;
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/cu_sequencer.sv
// Control-unit sequencer between IDU and ALU: owns PC and register file, issues the
// ALU command a cycle ahead of operands, writes back, resolves branches/jumps, halts on faults.
module cu_sequencer
    import cu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic                    soc_clk,
    input  logic                    reset,
    input  logic                    IDU_ready,
    output logic                    cu_ready,
    input  logic [5:0]              Instruction_to_CU,
    input  logic [4:0]              Instruction_to_ALU,
    input  logic [XLEN-1:0]         imm,
    input  logic [$clog2(NREG)-1:0] rd,
    input  logic [$clog2(NREG)-1:0] rs1,
    input  logic [$clog2(NREG)-1:0] rs2,
    input  logic [4:0]              shamt,
    input  logic [XLEN-1:0]         pc_increment,
    input  logic [1:0]              pipeline_override,
    input  logic                    invalid_instruction,
    output logic [4:0]              alu_cmd,
    output logic                    alu_cmd_valid,
    output logic [XLEN-1:0]         alu_in1,
    output logic [XLEN-1:0]         alu_in2,
    output logic                    alu_dat_ready,
    input  logic [XLEN-1:0]         alu_result,
    input  logic                    alu_result_valid,
    input  logic                    alu_branch_taken,
    input  logic                    ALU_err,
    output logic [XLEN-1:0]         pc,
    output logic                    halted,
    output logic [2:0]              halt_cause
);

    localparam int RW = $clog2(NREG);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, last_wb_q, last_wb_d, result_q, result_d;
    logic [XLEN-1:0] imm_q, imm_d, inc_q, inc_d;
    logic [XLEN-1:0] alu_in1_q, alu_in1_d, alu_in2_q, alu_in2_d;
    logic [5:0]      cls_q, cls_d;
    logic [4:0]      op_q, op_d, shamt_q, shamt_d, alu_cmd_q, alu_cmd_d;
    logic [RW-1:0]   rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [1:0]      ovr_q, ovr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [2:0]      halt_cause_q, halt_cause_d;
    logic            taken_q, taken_d, cu_ready_q, cu_ready_d, halted_q, halted_d;
    logic            alu_cmd_valid_q, alu_cmd_valid_d, alu_dat_ready_q, alu_dat_ready_d;

    logic            accept, rf_we;
    logic [XLEN-1:0] rdata1, rdata2, src1, src2, rf_wdata, jalr_tgt;

    cu_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .clk    (soc_clk),
        .rst_n  (reset),
        .raddr1 (rs1_q),
        .raddr2 (rs2_q),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .we     (rf_we),
        .waddr  (rd_q),
        .wdata  (rf_wdata)
    );

    assign accept   = (state_q == S_IDLE) && IDU_ready && cu_ready_q;
    assign src1     = ovr_q[FWD_RS1] ? last_wb_q : rdata1;
    assign src2     = ovr_q[FWD_RS2] ? last_wb_q : rdata2;
    assign jalr_tgt = src1 + imm_q;

    // Instruction fields are captured once at acceptance and held for the whole sequence.
    assign cls_d   = accept ? Instruction_to_CU  : cls_q;
    assign op_d    = accept ? Instruction_to_ALU : op_q;
    assign imm_d   = accept ? imm                : imm_q;
    assign inc_d   = accept ? pc_increment       : inc_q;
    assign rd_d    = accept ? rd                 : rd_q;
    assign rs1_d   = accept ? rs1                : rs1_q;
    assign rs2_d   = accept ? rs2                : rs2_q;
    assign shamt_d = accept ? shamt              : shamt_q;
    assign ovr_d   = accept ? pipeline_override  : ovr_q;

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        last_wb_d       = last_wb_q;
        result_d        = result_q;
        taken_d         = taken_q;
        cnt_d           = cnt_q;
        halt_cause_d    = halt_cause_q;
        alu_cmd_d       = alu_cmd_q;
        alu_cmd_valid_d = 1'b0;
        alu_in1_d       = alu_in1_q;
        alu_in2_d       = alu_in2_q;
        alu_dat_ready_d = 1'b0;
        rf_we           = 1'b0;
        rf_wdata        = '0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (invalid_instruction) begin
                        state_d      = S_HALT;
                        halt_cause_d = HC_INVALID;
                    end else if (Instruction_to_CU == CLS_ECALL) begin
                        state_d      = S_HALT;
                        halt_cause_d = HC_ECALL;
                    end else if (Instruction_to_CU == CLS_EBREAK) begin
                        state_d      = S_HALT;
                        halt_cause_d = HC_EBREAK;
                    end else if (Instruction_to_CU == CLS_LUI || Instruction_to_CU == CLS_JAL ||
                                 Instruction_to_CU == CLS_JALR) begin
                        state_d = S_JUMP;
                    end else if (is_alu_cls(Instruction_to_CU)) begin
                        state_d         = S_ISSUE;
                        alu_cmd_d       = Instruction_to_ALU;
                        alu_cmd_valid_d = 1'b1;
                    end else begin
                        state_d      = S_HALT;
                        halt_cause_d = HC_INVALID;
                    end
                end
            end
            S_ISSUE: begin
                if (ALU_err) begin
                    state_d      = S_HALT;
                    halt_cause_d = HC_ALU_ERR;
                end else begin
                    state_d         = S_EXEC;
                    alu_dat_ready_d = 1'b1;
                    alu_in1_d       = src1;
                    if (cls_q == CLS_ALU_I)       alu_in2_d = imm_q;
                    else if (cls_q == CLS_ALU_SH) alu_in2_d = {{(XLEN-5){1'b0}}, shamt_q};
                    else                          alu_in2_d = src2;
                end
            end
            S_EXEC: begin
                if (ALU_err) begin
                    state_d      = S_HALT;
                    halt_cause_d = HC_ALU_ERR;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                // An error outranks a result arriving in the same cycle.
                if (ALU_err) begin
                    state_d      = S_HALT;
                    halt_cause_d = HC_ALU_ERR;
                end else if (alu_result_valid) begin
                    state_d  = S_WB;
                    result_d = alu_result;
                    taken_d  = alu_branch_taken && (cls_q == CLS_BRANCH);
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d      = S_HALT;
                    halt_cause_d = HC_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WB: begin
                if (cls_q != CLS_BRANCH) begin
                    rf_we     = 1'b1;
                    rf_wdata  = result_q;
                    last_wb_d = result_q;
                end
                pc_d    = taken_q ? pc_q + imm_q : pc_q + inc_q;
                state_d = S_IDLE;
            end
            S_JUMP: begin
                rf_we    = 1'b1;
                rf_wdata = pc_q + inc_q;
                if (cls_q == CLS_LUI) begin
                    rf_wdata = imm_q;
                    pc_d     = pc_q + inc_q;
                end else if (cls_q == CLS_JAL) begin
                    pc_d = pc_q + imm_q;
                end else begin
                    pc_d = {jalr_tgt[XLEN-1:1], 1'b0};
                end
                last_wb_d = rf_wdata;
                state_d   = S_IDLE;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        cu_ready_d = (state_d == S_IDLE);
        halted_d   = (state_d == S_HALT);
    end

    always_ff @(posedge soc_clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            pc_q            <= RESET_PC;
            last_wb_q       <= '0;
            result_q        <= '0;
            taken_q         <= 1'b0;
            cnt_q           <= '0;
            halt_cause_q    <= HC_NONE;
            halted_q        <= 1'b0;
            cu_ready_q      <= 1'b0;
            alu_cmd_q       <= '0;
            alu_cmd_valid_q <= 1'b0;
            alu_in1_q       <= '0;
            alu_in2_q       <= '0;
            alu_dat_ready_q <= 1'b0;
            cls_q           <= '0;
            op_q            <= '0;
            imm_q           <= '0;
            inc_q           <= '0;
            rd_q            <= '0;
            rs1_q           <= '0;
            rs2_q           <= '0;
            shamt_q         <= '0;
            ovr_q           <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            last_wb_q       <= last_wb_d;
            result_q        <= result_d;
            taken_q         <= taken_d;
            cnt_q           <= cnt_d;
            halt_cause_q    <= halt_cause_d;
            halted_q        <= halted_d;
            cu_ready_q      <= cu_ready_d;
            alu_cmd_q       <= alu_cmd_d;
            alu_cmd_valid_q <= alu_cmd_valid_d;
            alu_in1_q       <= alu_in1_d;
            alu_in2_q       <= alu_in2_d;
            alu_dat_ready_q <= alu_dat_ready_d;
            cls_q           <= cls_d;
            op_q            <= op_d;
            imm_q           <= imm_d;
            inc_q           <= inc_d;
            rd_q            <= rd_d;
            rs1_q           <= rs1_d;
            rs2_q           <= rs2_d;
            shamt_q         <= shamt_d;
            ovr_q           <= ovr_d;
        end
    end

    assign cu_ready      = cu_ready_q;
    assign alu_cmd       = alu_cmd_q;
    assign alu_cmd_valid = alu_cmd_valid_q;
    assign alu_in1       = alu_in1_q;
    assign alu_in2       = alu_in2_q;
    assign alu_dat_ready = alu_dat_ready_q;
    assign pc            = pc_q;
    assign halted        = halted_q;
    assign halt_cause    = halt_cause_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// Directed bench for cu_sequencer: ALU operand expectations go through a scoreboard
// popped on alu_dat_ready; PC, register and halt state are checked at fixed steps.
module tb_cu_sequencer;
    import cu_pkg::*;

    localparam int TO = 15;

    logic        soc_clk = 1'b0;
    logic        reset;
    logic        IDU_ready, cu_ready, invalid_instruction;
    logic [5:0]  Instruction_to_CU;
    logic [4:0]  Instruction_to_ALU, shamt, alu_cmd;
    logic [31:0] imm, pc_increment, alu_in1, alu_in2, alu_result, pc;
    logic [4:0]  rd, rs1, rs2;
    logic [1:0]  pipeline_override;
    logic        alu_cmd_valid, alu_dat_ready, alu_result_valid, alu_branch_taken, ALU_err, halted;
    logic [2:0]  halt_cause;

    cu_sequencer #(.XLEN(32), .NREG(32), .RESET_PC(32'h0), .TIMEOUT(TO)) dut (
        .soc_clk(soc_clk), .reset(reset), .IDU_ready(IDU_ready), .cu_ready(cu_ready),
        .Instruction_to_CU(Instruction_to_CU), .Instruction_to_ALU(Instruction_to_ALU),
        .imm(imm), .rd(rd), .rs1(rs1), .rs2(rs2), .shamt(shamt), .pc_increment(pc_increment),
        .pipeline_override(pipeline_override), .invalid_instruction(invalid_instruction),
        .alu_cmd(alu_cmd), .alu_cmd_valid(alu_cmd_valid), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_dat_ready(alu_dat_ready), .alu_result(alu_result), .alu_result_valid(alu_result_valid),
        .alu_branch_taken(alu_branch_taken), .ALU_err(ALU_err), .pc(pc), .halted(halted),
        .halt_cause(halt_cause)
    );

    always #5 soc_clk = ~soc_clk;

    typedef struct {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  op;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge soc_clk);
        #1;
    endtask

    function automatic logic [31:0] rf(input int idx);
        return dut.u_rf.regs_q[idx];
    endfunction

    // Operands are compared whenever the DUT presents them.
    always @(negedge soc_clk) begin
        if (alu_dat_ready === 1'b1) begin
            chk("sb_depth", sb_q.size(), 1);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("alu_in1", alu_in1, e.in1);
                chk("alu_in2", alu_in2, e.in2);
                chk("alu_cmd", {27'd0, alu_cmd}, {27'd0, e.op});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(input string tag);
        int n = 0;
        while (cu_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, cu_ready}, 1);
    endtask

    task automatic accept(input logic [5:0] cls, input logic [4:0] op, input logic [4:0] d,
                          input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im,
                          input logic [4:0] sh, input logic [1:0] ovr, input logic inv);
        wait_ready("ready_before_accept");
        Instruction_to_CU   = cls;
        Instruction_to_ALU  = op;
        rd                  = d;
        rs1                 = s1;
        rs2                 = s2;
        imm                 = im;
        shamt               = sh;
        pipeline_override   = ovr;
        invalid_instruction = inv;
        IDU_ready           = 1'b1;
        tick();
        IDU_ready           = 1'b0;
        invalid_instruction = 1'b0;
    endtask

    task automatic run_alu(input logic [5:0] cls, input logic [4:0] op, input logic [4:0] d,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im,
                           input logic [4:0] sh, input logic [1:0] ovr,
                           input logic [31:0] e1, input logic [31:0] e2,
                           input logic [31:0] res, input logic tk);
        sb_q.push_back('{e1, e2, op});
        accept(cls, op, d, s1, s2, im, sh, ovr, 1'b0);
        chk("cmd_valid_c1", {31'd0, alu_cmd_valid}, 1);
        chk("ready_low_c1", {31'd0, cu_ready}, 0);
        tick();
        chk("dat_ready_c2", {31'd0, alu_dat_ready}, 1);
        tick();
        alu_result       = res;
        alu_branch_taken = tk;
        alu_result_valid = 1'b1;
        tick();
        alu_result_valid = 1'b0;
        alu_branch_taken = 1'b0;
        chk("ready_low_wb", {31'd0, cu_ready}, 0);
        tick();
        chk("ready_back", {31'd0, cu_ready}, 1);
    endtask

    task automatic run_jump(input logic [5:0] cls, input logic [4:0] d, input logic [4:0] s1,
                            input logic [31:0] im);
        accept(cls, 5'd0, d, s1, 5'd0, im, 5'd0, 2'b00, 1'b0);
        chk("jump_ready_low", {31'd0, cu_ready}, 0);
        chk("jump_no_cmd", {31'd0, alu_cmd_valid}, 0);
        tick();
        chk("jump_ready_2cyc", {31'd0, cu_ready}, 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("ready_after_reset", {31'd0, cu_ready}, 1);
    endtask

    task automatic halt_on(input string tag, input logic [5:0] cls, input logic inv,
                           input logic [2:0] cause);
        do_reset();
        accept(cls, 5'd0, 5'd5, 5'd0, 5'd0, 32'd3, 5'd0, 2'b00, inv);
        chk({tag, "_halted"}, {31'd0, halted}, 1);
        chk({tag, "_cause"}, {29'd0, halt_cause}, {29'd0, cause});
        chk({tag, "_no_cmd"}, {31'd0, alu_cmd_valid}, 0);
        IDU_ready = 1'b1;
        tick();
        tick();
        IDU_ready = 1'b0;
        chk({tag, "_sticky"}, {31'd0, halted}, 1);
        chk({tag, "_ready_low"}, {31'd0, cu_ready}, 0);
        chk({tag, "_no_cmd_late"}, {31'd0, alu_cmd_valid}, 0);
        chk({tag, "_pc"}, pc, 0);
    endtask

    initial begin
        reset = 1'b0;
        IDU_ready = 0; invalid_instruction = 0; Instruction_to_CU = 0; Instruction_to_ALU = 0;
        imm = 0; rd = 0; rs1 = 0; rs2 = 0; shamt = 0; pc_increment = 32'd4;
        pipeline_override = 0; alu_result = 0; alu_result_valid = 0; alu_branch_taken = 0;
        ALU_err = 0;
        #2;
        chk("rst_pc", pc, 0);
        chk("rst_cu_ready", {31'd0, cu_ready}, 0);
        chk("rst_halted", {31'd0, halted}, 0);
        chk("rst_cause", {29'd0, halt_cause}, 0);
        chk("rst_cmd_valid", {31'd0, alu_cmd_valid}, 0);
        chk("rst_dat_ready", {31'd0, alu_dat_ready}, 0);
        chk("rst_in1", alu_in1, 0);
        chk("rst_cmd", {27'd0, alu_cmd}, 0);
        tick();
        reset = 1'b1;
        chk("ready_low_before_edge", {31'd0, cu_ready}, 0);
        tick();
        chk("ready_first_edge", {31'd0, cu_ready}, 1);

        // ADDI x5 = x0 + 7
        run_alu(CLS_ALU_I, 5'd0, 5'd5, 5'd0, 5'd0, 32'd7, 5'd0, 2'b00, 32'd0, 32'd7, 32'd7, 1'b0);
        chk("addi_r5", rf(5), 32'd7);
        chk("addi_pc", pc, 32'h4);
        // Forwarding: result to x0 is still captured as last_wb
        run_alu(CLS_ALU_R, 5'd0, 5'd0, 5'd5, 5'd5, 32'd0, 5'd0, 2'b00, 32'd7, 32'd7, 32'h55, 1'b0);
        chk("x0_stays_zero", rf(0), 0);
        chk("pc_8", pc, 32'h8);
        run_alu(CLS_ALU_R, 5'd0, 5'd6, 5'd0, 5'd5, 32'd0, 5'd0, 2'b01, 32'h55, 32'd7, 32'h99, 1'b0);
        chk("fwd_r6", rf(6), 32'h99);
        run_alu(CLS_ALU_R, 5'd0, 5'd8, 5'd0, 5'd5, 32'd0, 5'd0, 2'b00, 32'd0, 32'd7, 32'h10, 1'b0);
        chk("nofwd_r8", rf(8), 32'h10);
        chk("pc_10", pc, 32'h10);
        // Branches
        run_alu(CLS_BRANCH, 5'd8, 5'd5, 5'd5, 5'd6, 32'hFFFF_FFF8, 5'd0, 2'b00,
                32'd7, 32'h99, 32'd1, 1'b1);
        chk("br_taken_pc", pc, 32'h8);
        chk("br_no_wb", rf(5), 32'd7);
        run_alu(CLS_BRANCH, 5'd8, 5'd5, 5'd5, 5'd6, 32'h40, 5'd0, 2'b00,
                32'd7, 32'h99, 32'd0, 1'b0);
        chk("br_not_taken_pc", pc, 32'hC);
        chk("br_nt_no_wb", rf(5), 32'd7);
        // Shift uses zero-extended shamt; then both operands forwarded
        run_alu(CLS_ALU_SH, 5'd1, 5'd7, 5'd6, 5'd0, 32'hFFFF_FFFF, 5'd3, 2'b00,
                32'h99, 32'd3, 32'h4C8, 1'b0);
        chk("sh_r7", rf(7), 32'h4C8);
        run_alu(CLS_ALU_R, 5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 5'd0, 2'b11,
                32'h4C8, 32'h4C8, 32'h101, 1'b0);
        chk("fwd11_r3", rf(3), 32'h101);
        chk("pc_14", pc, 32'h14);
        // JAL, JALR, LUI
        run_jump(CLS_JAL, 5'd9, 5'd0, 32'hC);
        chk("jal_link", rf(9), 32'h18);
        chk("jal_pc", pc, 32'h20);
        run_jump(CLS_JALR, 5'd10, 5'd3, 32'd4);
        chk("jalr_link", rf(10), 32'h24);
        chk("jalr_pc", pc, 32'h104);
        run_jump(CLS_LUI, 5'd11, 5'd0, 32'h1234_5000);
        chk("lui_r11", rf(11), 32'h1234_5000);
        chk("lui_pc", pc, 32'h108);

        // Reset asserted while waiting for the ALU
        sb_q.push_back('{32'd0, 32'd1, 5'd0});
        accept(CLS_ALU_I, 5'd0, 5'd5, 5'd0, 5'd0, 32'd1, 5'd0, 2'b00, 1'b0);
        tick();
        tick();
        alu_result = 32'hDEAD;
        reset = 1'b0;
        #1;
        chk("midrst_pc", pc, 0);
        chk("midrst_halted", {31'd0, halted}, 0);
        chk("midrst_r5", rf(5), 0);
        chk("midrst_r11", rf(11), 0);
        chk("midrst_ready", {31'd0, cu_ready}, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_ready_back", {31'd0, cu_ready}, 1);

        halt_on("invalid", CLS_ALU_I, 1'b1, HC_INVALID);
        halt_on("unknown_cls", 6'h3F, 1'b0, HC_INVALID);
        halt_on("ecall", CLS_ECALL, 1'b0, HC_ECALL);
        halt_on("ebreak", CLS_EBREAK, 1'b0, HC_EBREAK);

        // ALU_err wins over a simultaneous result
        do_reset();
        sb_q.push_back('{32'd0, 32'd9, 5'd0});
        accept(CLS_ALU_I, 5'd0, 5'd5, 5'd0, 5'd0, 32'd9, 5'd0, 2'b00, 1'b0);
        tick();
        tick();
        alu_result = 32'd9;
        alu_result_valid = 1'b1;
        ALU_err = 1'b1;
        tick();
        alu_result_valid = 1'b0;
        ALU_err = 1'b0;
        chk("aluerr_halted", {31'd0, halted}, 1);
        chk("aluerr_cause", {29'd0, halt_cause}, {29'd0, HC_ALU_ERR});
        tick();
        chk("aluerr_r5", rf(5), 0);
        chk("aluerr_pc", pc, 0);

        // Timeout: halts after TIMEOUT cycles in WAIT
        do_reset();
        sb_q.push_back('{32'd0, 32'd2, 5'd0});
        accept(CLS_ALU_I, 5'd0, 5'd5, 5'd0, 5'd0, 32'd2, 5'd0, 2'b00, 1'b0);
        tick();
        begin
            int n = 0;
            while (halted !== 1'b1 && n < 60) begin
                tick();
                n++;
            end
            chk("timeout_cycles", n, TO + 1);
        end
        chk("timeout_cause", {29'd0, halt_cause}, {29'd0, HC_TIMEOUT});
        chk("timeout_r5", rf(5), 0);
        chk("timeout_pc", pc, 0);

        chk("sb_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
